// File: rtl/ife_pkg.sv
// Shared types and default widths for the IFE dispatch unit.
package ife_pkg;

  localparam int unsigned IFE_BLOCK_ID_W = 8;
  localparam int unsigned IFE_PC_W       = 64;
  localparam int unsigned IFE_CNT_W      = 16;
  localparam int unsigned IFE_TIMEOUT    = 1024;

  // Dispatch sequencing states
  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    DISPATCH     = 3'd1,
    WAIT_PAR     = 3'd2,
    COMPARE      = 3'd3,
    SERIAL_START = 3'd4,
    SERIAL_WAIT  = 3'd5,
    RETIRE       = 3'd6
  } ife_disp_state_t;

  // Block descriptor at the default widths
  typedef struct packed {
    logic [IFE_BLOCK_ID_W-1:0] id;
    logic [IFE_PC_W-1:0]       pc;
  } ife_block_desc_t;

endpackage

// File: rtl/ife_watchdog.sv
// Wait-state watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the LIMIT-th enabled cycle is reached.
module ife_watchdog #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  // expired is raised during the LIMIT-th enabled cycle
  assign expired = en && (cnt >= W'(LIMIT - 1));

  // count enabled cycles, restarting on every state entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (clr)            cnt <= '0;
    else if (en && !expired) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/ife_dispatch_unit.sv
// IFE dispatch unit: runs each block on both cores in parallel, hands it to
// the commit comparator, and on mismatch re-runs it serially on core 0.
// Optional watchdog on the wait states: define IFE_DISPATCH_WATCHDOG_EN.
module ife_dispatch_unit
  import ife_pkg::*;
#(
  parameter int unsigned BLOCK_ID_WIDTH = IFE_BLOCK_ID_W,
  parameter int unsigned PC_WIDTH       = IFE_PC_W,
  parameter int unsigned CNT_WIDTH      = IFE_CNT_W,
  parameter int unsigned TIMEOUT_CYCLES = IFE_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      blk_valid,
  output logic                      blk_ready,
  input  logic [BLOCK_ID_WIDTH-1:0] blk_id,
  input  logic [PC_WIDTH-1:0]       blk_pc,
  output logic                      core0_start,
  output logic                      core1_start,
  output logic [PC_WIDTH-1:0]       core_pc,
  output logic                      core_serial,
  input  logic                      core0_done,
  input  logic                      core1_done,
  output logic                      cmp_valid,
  output logic [BLOCK_ID_WIDTH-1:0] cmp_block_id,
  input  logic                      commit_ok,
  input  logic                      commit_fail,
  input  logic                      reexecute_serial,
  output logic                      retire_valid,
  output logic [BLOCK_ID_WIDTH-1:0] retire_id,
  output logic                      retire_serial,
  output logic                      busy,
  output logic [CNT_WIDTH-1:0]      serial_count,
  output logic                      timeout_err
);

  ife_disp_state_t           state, state_d;
  logic [BLOCK_ID_WIDTH-1:0] id_q;
  logic [PC_WIDTH-1:0]       pc_q;
  logic                      done0_q, done1_q, serial_q;
  logic [CNT_WIDTH-1:0]      cnt_q;
  logic                      wd_expired;
  logic                      both_done;

  // done pulses count together with earlier sticky flags
  assign both_done = (done0_q || core0_done) && (done1_q || core1_done);

`ifdef IFE_DISPATCH_WATCHDOG_EN
  logic tmo_q;
  logic tmo_fire;

  ife_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wd (
    .clk     (clk),
    .rst_n   (rst),
    .clr     (state_d != state),
    .en      ((state == WAIT_PAR) || (state == SERIAL_WAIT)),
    .expired (wd_expired)
  );

  // a timeout only counts when it is what moves the FSM on
  assign tmo_fire = wd_expired &&
                    (((state == WAIT_PAR) && !both_done) ||
                     ((state == SERIAL_WAIT) && !core0_done));

  // registered one-cycle timeout pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tmo_q <= 1'b0;
    else      tmo_q <= tmo_fire;
  end

  assign timeout_err = tmo_q;
`else
  assign wd_expired  = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // next-state selection; fail/reexecute outrank ok
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:         if (blk_valid) state_d = DISPATCH;
      DISPATCH:     state_d = WAIT_PAR;
      WAIT_PAR: begin
        if (both_done)       state_d = COMPARE;
        else if (wd_expired) state_d = SERIAL_START;
      end
      COMPARE: begin
        if (commit_fail || reexecute_serial) state_d = SERIAL_START;
        else if (commit_ok)                  state_d = RETIRE;
      end
      SERIAL_START: state_d = SERIAL_WAIT;
      SERIAL_WAIT:  if (core0_done || wd_expired) state_d = RETIRE;
      RETIRE:       state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  // state, latched block, sticky done flags, serial flag and statistics
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      id_q     <= '0;
      pc_q     <= '0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      serial_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state <= state_d;
      unique case (state)
        IDLE: if (blk_valid) begin
          id_q <= blk_id;
          pc_q <= blk_pc;
        end
        DISPATCH: begin
          done0_q  <= 1'b0;
          done1_q  <= 1'b0;
          serial_q <= 1'b0;
        end
        WAIT_PAR: begin
          if (core0_done) done0_q <= 1'b1;
          if (core1_done) done1_q <= 1'b1;
        end
        SERIAL_START: begin
          serial_q <= 1'b1;
          if (cnt_q != {CNT_WIDTH{1'b1}}) cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // outputs decoded from state and latched registers only
  assign blk_ready     = (state == IDLE);
  assign busy          = (state != IDLE);
  assign core0_start   = (state == DISPATCH) || (state == SERIAL_START);
  assign core1_start   = (state == DISPATCH);
  assign core_serial   = (state == SERIAL_START) || (state == SERIAL_WAIT);
  assign core_pc       = (state == IDLE) ? '0 : pc_q;
  assign cmp_valid     = (state == COMPARE);
  assign cmp_block_id  = (state == COMPARE) ? id_q : '0;
  assign retire_valid  = (state == RETIRE);
  assign retire_id     = (state == RETIRE) ? id_q : '0;
  assign retire_serial = (state == RETIRE) && serial_q;
  assign serial_count  = cnt_q;

endmodule

// File: tb/tb_ife_dispatch_unit.sv
// Scoreboard bench for ife_dispatch_unit: the driver pushes expected start,
// compare and retire events when it issues a block; a negedge monitor pops
// and compares whenever the DUT presents one.
module tb_ife_dispatch_unit;

  localparam int BW = 8;
  localparam int PW = 64;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          blk_valid = 1'b0;
  logic          blk_ready;
  logic [BW-1:0] blk_id = '0;
  logic [PW-1:0] blk_pc = '0;
  logic          core0_start, core1_start, core_serial;
  logic [PW-1:0] core_pc;
  logic          core0_done = 1'b0, core1_done = 1'b0;
  logic          cmp_valid;
  logic [BW-1:0] cmp_block_id;
  logic          commit_ok = 1'b0, commit_fail = 1'b0, reexecute_serial = 1'b0;
  logic          retire_valid, retire_serial, busy, timeout_err;
  logic [BW-1:0] retire_id;
  logic [CW-1:0] serial_count;

  ife_dispatch_unit #(.BLOCK_ID_WIDTH(BW), .PC_WIDTH(PW), .CNT_WIDTH(CW),
                      .TIMEOUT_CYCLES(1024)) dut (
    .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_id(blk_id), .blk_pc(blk_pc), .core0_start(core0_start),
    .core1_start(core1_start), .core_pc(core_pc), .core_serial(core_serial),
    .core0_done(core0_done), .core1_done(core1_done), .cmp_valid(cmp_valid),
    .cmp_block_id(cmp_block_id), .commit_ok(commit_ok),
    .commit_fail(commit_fail), .reexecute_serial(reexecute_serial),
    .retire_valid(retire_valid), .retire_id(retire_id),
    .retire_serial(retire_serial), .busy(busy), .serial_count(serial_count),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  int last_done_cyc = 0;
  int model_cnt = 0;

  typedef struct { logic [PW-1:0] pc; bit serial; } start_t;
  typedef struct { logic [BW-1:0] id; bit serial; int cnt; } ret_t;

  start_t        start_q[$];
  logic [BW-1:0] cmp_q[$];
  ret_t          ret_q[$];

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // monitor: compare every start, compare request and retire against the queues
  bit     cmp_prev = 1'b0;
  start_t s;
  ret_t   r;
  logic [BW-1:0] ei;
  always @(negedge clk) begin
    if (rst) begin
      if (core0_start) begin
        if (start_q.size() == 0) chk("unexpected_start", 1, 0);
        else begin
          s = start_q.pop_front();
          chk("start_core_pc", core_pc, s.pc);
          chk("start_core1", core1_start, !s.serial);
          chk("start_serial", core_serial, s.serial);
        end
      end
      if (cmp_valid && !cmp_prev) begin
        if (cmp_q.size() == 0) chk("unexpected_cmp", 1, 0);
        else begin
          ei = cmp_q.pop_front();
          chk("cmp_block_id", cmp_block_id, ei);
          chk("cmp_latency", cyc, last_done_cyc + 1);
        end
      end
      if (retire_valid) begin
        if (ret_q.size() == 0) chk("unexpected_retire", 1, 0);
        else begin
          r = ret_q.pop_front();
          chk("retire_id", retire_id, r.id);
          chk("retire_serial", retire_serial, r.serial);
          chk("serial_count", serial_count, r.cnt);
        end
      end
      if (blk_ready && core_pc != '0) chk("idle_core_pc", core_pc, 0);
`ifndef IFE_DISPATCH_WATCHDOG_EN
      if (timeout_err) chk("timeout_err", timeout_err, 0);
`endif
    end
    cmp_prev = cmp_valid && rst;
  end

  // bounded wait at negedges: 0 ready, 1 core0_start, 2 cmp_valid, 3 retire
  task automatic wait_for(input int which, input string nm);
    int t = 0;
    bit hit = 1'b0;
    forever begin
      case (which)
        0:       hit = blk_ready;
        1:       hit = core0_start;
        2:       hit = cmp_valid;
        default: hit = retire_valid;
      endcase
      if (hit || t >= 300) break;
      @(negedge clk);
      t++;
    end
    if (!hit) chk({"wait_", nm}, 0, 1);
  endtask

  // verdict: 0 ok, 1 fail, 2 reexecute, 3 ok+fail together
  task automatic run_blk(input logic [BW-1:0] id, input logic [PW-1:0] pc,
                         input int l0, input int l1, input int verdict,
                         input int vdel, input int sl);
    bit ser;
    int mx;
    ser = (verdict != 0);
    mx  = (l0 > l1) ? l0 : l1;
    start_q.push_back('{pc, 1'b0});
    cmp_q.push_back(id);
    if (ser) begin
      start_q.push_back('{pc, 1'b1});
      if (model_cnt < (1 << CW) - 1) model_cnt++;
    end
    ret_q.push_back('{id, ser, model_cnt});

    wait_for(0, "ready");
    blk_valid = 1'b1; blk_id = id; blk_pc = pc;
    @(negedge clk);
    blk_valid = 1'b0; blk_id = BW'($urandom); blk_pc = {$urandom, $urandom};
    wait_for(1, "start");
    for (int k = 1; k <= mx; k++) begin
      @(negedge clk);
      core0_done = (k == l0);
      core1_done = (k == l1);
    end
    last_done_cyc = cyc;
    @(negedge clk);
    core0_done = 1'b0; core1_done = 1'b0;
    wait_for(2, "cmp");
    repeat (vdel) @(negedge clk);
    commit_ok        = (verdict == 0) || (verdict == 3);
    commit_fail      = (verdict == 1) || (verdict == 3);
    reexecute_serial = (verdict == 2);
    @(negedge clk);
    commit_ok = 1'b0; commit_fail = 1'b0; reexecute_serial = 1'b0;
    if (ser) begin
      wait_for(1, "serial_start");
      for (int k = 1; k <= sl; k++) begin
        @(negedge clk);
        core0_done = (k == sl);
        core1_done = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      core0_done = 1'b0; core1_done = 1'b0;
    end
    wait_for(3, "retire");
    @(negedge clk);
  endtask

  initial begin
    #1;
    chk("rst_blk_ready", blk_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_core_start", {core0_start, core1_start}, 0);
    chk("rst_retire", retire_valid, 0);
    chk("rst_serial_count", serial_count, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // reset while waiting on the cores drops the block
    start_q.push_back('{64'h0000_0000_0000_7700, 1'b0});
    wait_for(0, "ready");
    blk_valid = 1'b1; blk_id = 8'h12; blk_pc = 64'h7700;
    @(negedge clk);
    blk_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_blk_ready", blk_ready, 1);
    chk("midrst_retire", retire_valid, 0);
    chk("midrst_serial_count", serial_count, 0);
    repeat (2) @(negedge clk);
    chk("midrst_retire_held", retire_valid, 0);
    rst = 1'b1;
    start_q.delete(); cmp_q.delete(); ret_q.delete();

    run_blk(8'h05, 64'h1000, 6, 3, 0, 0, 1);   // core1 first, ok path
    run_blk(8'h33, 64'h3300, 4, 4, 0, 1, 1);   // simultaneous done
    run_blk(8'hA0, 64'h2000, 2, 5, 1, 0, 3);   // fail -> serial
    run_blk(8'h44, 64'h4400, 1, 1, 3, 0, 1);   // ok+fail -> serial
    for (int i = 0; i < 3; i++)                 // drive serial_count into saturation
      run_blk(8'(8'h50 + i), 64'h5000 + 64'(i), 2, 1, 1, i, 2);
    run_blk(8'h60, 64'h6000, 1, 2, 2, 2, 1);   // reexecute_serial

    for (int i = 0; i < 40; i++)
      run_blk(BW'($urandom), {$urandom, $urandom}, $urandom_range(1, 6),
              $urandom_range(1, 6), $urandom_range(0, 3),
              $urandom_range(0, 2), $urandom_range(1, 4));

    repeat (4) @(negedge clk);
    chk("start_q_drained", start_q.size(), 0);
    chk("cmp_q_drained", cmp_q.size(), 0);
    chk("ret_q_drained", ret_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/ife_dispatch_unit.md
Name: ife_dispatch_unit

Overview:
- Issues one instruction block to both cores for duplicated parallel execution.
- Waits for both cores to finish, then presents the block to the commit comparator (valid + block_id).
- Consumes the comparator's ok/fail/reexecute_serial verdict. On fail, re-runs the block serially on core 0, then retires it.
- Sits between the block fetch/expander front end and the dual-core execution/commit path.

Parameters:
- BLOCK_ID_WIDTH, 8, width of block identifier.
- PC_WIDTH, 64, width of block start address.
- CNT_WIDTH, 16, width of saturating serial-reexecution statistics counter.
- TIMEOUT_CYCLES, 1024, watchdog limit (used only with optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- blk_valid  in  1  new block offered.
- blk_ready  out  1  unit can accept a block.
- blk_id  in  BLOCK_ID_WIDTH  offered block id.
- blk_pc  in  PC_WIDTH  offered block start PC.
- core0_start  out  1  start pulse to core 0.
- core1_start  out  1  start pulse to core 1.
- core_pc  out  PC_WIDTH  start PC driven to both cores.
- core_serial  out  1  core 0 is in serial re-execution mode.
- core0_done  in  1  core 0 finished (single-cycle pulse).
- core1_done  in  1  core 1 finished (single-cycle pulse).
- cmp_valid  out  1  request comparison (to comparator valid_in).
- cmp_block_id  out  BLOCK_ID_WIDTH  block id to comparator.
- commit_ok  in  1  comparator: results match.
- commit_fail  in  1  comparator: mismatch.
- reexecute_serial  in  1  comparator: serial re-execution required.
- retire_valid  out  1  block retired (1-cycle pulse).
- retire_id  out  BLOCK_ID_WIDTH  retired block id.
- retire_serial  out  1  retired block went through the serial path.
- busy  out  1  state != IDLE.
- serial_count  out  CNT_WIDTH  saturating count of serial re-executions.

Behaviour:
- Reset (rst=0, async): state=IDLE.
  - All outputs 0 except blk_ready=1.
  - Latched id/pc = 0, done flags cleared, serial_count=0.
  - An in-flight block is dropped with no retire.
- IDLE:
  - blk_ready=1.
  - On blk_valid && blk_ready: latch blk_id and blk_pc, go to DISPATCH.
- DISPATCH:
  - One cycle; core0_start=core1_start=1; core_pc=latched pc.
  - Clear done0/done1 flags, go to WAIT_PAR.
- WAIT_PAR:
  - Sticky flags set on core0_done / core1_done.
  - Done pulses may arrive in any order or the same cycle.
  - Exit to COMPARE in the cycle after both flags are set.
  - Done pulses in DISPATCH are ignored.
- COMPARE:
  - cmp_valid=1 and cmp_block_id=latched id, held until a verdict.
  - Comparator is combinational; verdict is sampled in the same cycle.
  - commit_ok && !commit_fail: go to RETIRE with serial flag=0.
  - commit_fail or reexecute_serial: go to SERIAL_START. Fail has priority if ok is asserted simultaneously.
  - No verdict: stay in COMPARE.
- SERIAL_START:
  - One cycle; core0_start=1, core_serial=1, core1_start=0.
  - serial_count increments, saturating at all-ones.
  - Go to SERIAL_WAIT.
- SERIAL_WAIT:
  - core_serial=1.
  - On core0_done: go to RETIRE with serial flag=1. No second comparison.
  - core1_done is ignored.
- RETIRE:
  - One cycle; retire_valid=1, retire_id=latched id, retire_serial=serial flag.
  - Go to IDLE.
  - blk_ready stays 0 in this cycle (no back-to-back accept).
- Latency, ok path: accept → retire = 3 + core latency + 1 cycles.
- core_pc holds the latched PC outside IDLE and is 0 in IDLE.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output except cmp_valid held, which is state-decoded.

Optional Feature:
- Macro IFE_DISPATCH_WATCHDOG_EN.
- With the macro:
  - A cycle counter runs in WAIT_PAR and SERIAL_WAIT.
  - In WAIT_PAR, reaching TIMEOUT_CYCLES forces SERIAL_START and pulses output port timeout_err for 1 cycle.
  - In SERIAL_WAIT, reaching TIMEOUT_CYCLES retires with retire_serial=1 and pulses timeout_err.
  - The counter clears on every state entry.
- Without the macro:
  - No counter; waits are unbounded.
  - timeout_err port is still present and tied to 0.

Decomposition:
- Shared package ife_pkg holds:
  - enum ife_disp_state_t (IDLE, DISPATCH, WAIT_PAR, COMPARE, SERIAL_START, SERIAL_WAIT, RETIRE);
  - struct ife_block_desc_t {id, pc};
  - default width constants.
- One sub-module: ife_watchdog (counter + threshold compare, clear/enable inputs). It is instantiated only under the macro.

Test Plan:
- Reset mid-WAIT_PAR (rst low at cycle 5 after accept id=0x12) → busy=0, blk_ready=1, no retire_valid, serial_count=0.
- Accept id=0x05 pc=0x1000; core1_done at +3, core0_done at +6; commit_ok → single retire_valid with retire_id=0x05, retire_serial=0; core_pc=0x1000 during both start pulses.
- core0_done and core1_done in the same cycle → exactly one cycle later cmp_valid=1, cmp_block_id correct.
- Accept id=0xA0; commit_fail=1 → core0_start only, core_serial=1; core0_done → retire_id=0xA0, retire_serial=1, serial_count=1.
- commit_ok and commit_fail both 1 → serial path taken; with CNT_WIDTH=2 and 5 fails, serial_count saturates at 3.
- With IFE_DISPATCH_WATCHDOG_EN and TIMEOUT_CYCLES=8, core1 never done → timeout_err pulse after 8 WAIT_PAR cycles, serial re-exec, then retire_serial=1.
